uart_tx_frame_ctrl: RTL and testbench
=====================================

# uart_tx_frame_ctrl

Parametrised UART transmit engine. Combines the frame FSM, serializer, parity generator and line mux in one block, sitting between the system-side TX data path and the serial TX pin. Supports a configurable data width, even or odd parity with parity on or off per frame, one or two stop bits, and back-to-back frames with no idle gap. CLK is the baud-rate clock: one serial bit is sent per CLK cycle.

## Interface
- DATA_WIDTH, 8: payload bits per frame, legal range 5..9.
- CLK  in  1  baud-rate clock; all state changes on the rising edge.
- RST  in  1  asynchronous, active-low reset.
- P_DATA  in  DATA_WIDTH  parallel payload; sampled only on accept.
- DATA_VALID  in  1  payload request; a one-cycle pulse or level.
- PAR_EN  in  1  1 = parity bit present; sampled on accept.
- PAR_TYP  in  1  0 = even, 1 = odd; sampled on accept.
- STOP_2  in  1  1 = two stop bits, 0 = one; sampled on accept.
- TX_OUT  out  1  serial line; idle level is 1; registered.
- busy  out  1  1 while a frame is on the line; registered.

## Operation
- States: IDLE, START, DATA, PARITY, STOP1, STOP2.
- Accept event: on a rising edge where DATA_VALID=1 and the state is IDLE, or the state is the final stop state.
  - The final stop state is STOP1 when latched STOP_2=0, otherwise STOP2.
- On accept, latch P_DATA, PAR_EN, PAR_TYP and STOP_2 into internal registers. Input changes after accept do not affect the current frame.
- DATA_VALID in any other state is ignored. There is no queueing.
- Transitions:
  - IDLE → START on accept.
  - START → DATA.
  - DATA stays for DATA_WIDTH cycles. On the last bit it goes to PARITY if latched PAR_EN=1, else to STOP1.
  - PARITY → STOP1.
  - STOP1 → STOP2 if latched STOP_2=1.
  - Final stop state → START on accept, else → IDLE.
- Line values:
  - IDLE = 1, START = 0.
  - DATA = data bits, LSB first.
  - PARITY = ^data XOR latched PAR_TYP, so even gives the XOR reduction and odd gives its inverse.
  - STOP1 and STOP2 = 1.
- busy = 1 in every state except IDLE.
- Bit counter width is $clog2(DATA_WIDTH). It clears on entry to DATA; ser_done asserts when the counter equals DATA_WIDTH-1.

## Timing
- Reset (RST low, any time, including mid-frame): state = IDLE, TX_OUT = 1, busy = 0, shift register and counter cleared, latched config cleared. Takes effect immediately, not on the next edge.
- Latency: accept at edge k gives TX_OUT=0 and busy=1 during cycle k+1, the first cycle after edge k.
- Frame length: 1 + DATA_WIDTH + PAR_EN + (1 + STOP_2) cycles.
- Back-to-back frames: an accept in the final stop cycle starts the next START immediately. busy stays 1 with no glitch, and the stop-bit count is still honoured.
- Without an accept in the final stop cycle, busy falls to 0 on the following edge and TX_OUT stays 1.
- TX_OUT and busy are flop outputs, loaded on the edge that enters each state, so they are glitch-free.
- If DATA_VALID rises together with an asynchronous reset release, it is ignored until the first full edge with RST high.

## Structure
- Shared package uart_pkg holds:
  - the state encoding localparams (3-bit, binary);
  - PAR_EVEN = 1'b0 and PAR_ODD = 1'b1;
  - the default DATA_WIDTH.
- Sub-module uart_tx_serializer:
  - DATA_WIDTH-wide load/shift register plus bit counter;
  - inputs: load, shift enable;
  - outputs: ser_data, ser_done.
- The top level holds the FSM, the parity XOR on the latched word, the output mux and the output flops.

## Test plan
- DATA_WIDTH=8, P_DATA=0xA5, PAR_EN=0, STOP_2=0: TX_OUT sequence is 0,1,0,1,0,0,1,0,1,1 over 10 cycles, then idles at 1; busy is high for exactly 10 cycles.
- 0xA5 with PAR_EN=1, PAR_TYP=0: parity bit = 0, 11-cycle frame. Same with PAR_TYP=1: parity bit = 1.
- 0x0F with PAR_EN=1, PAR_TYP=1, STOP_2=1: data 1,1,1,1,0,0,0,0, parity 1, stop 1,1; 12-cycle frame.
- Back-to-back: DATA_VALID held high with 0x3C then 0xC3. The second START follows the first frame's final stop bit in the next cycle, and busy never drops. P_DATA changed mid-frame does not alter the first frame.
- Reset mid-frame: RST pulled low in the 4th data bit. TX_OUT=1 and busy=0 immediately; after release with DATA_VALID=0 the line stays idle.
- DATA_WIDTH=5, P_DATA=5'b10011, PAR_EN=1, PAR_TYP=0: frame 0,1,1,0,0,1,1,1, which is 8 cycles with parity bit = 1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: state encoding, parity
// polarity constants and the default payload width.
package uart_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 8;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP1  = 3'd4;
    localparam logic [2:0] ST_STOP2  = 3'd5;

    typedef enum logic [2:0] {
        StIdle   = ST_IDLE,
        StStart  = ST_START,
        StData   = ST_DATA,
        StParity = ST_PARITY,
        StStop1  = ST_STOP1,
        StStop2  = ST_STOP2
    } tx_state_e;

endpackage

// File: rtl/uart_tx_serializer.sv
// Payload shift register and bit counter. ser_data always presents the next
// bit to be driven onto the line; ser_done flags the final data bit cycle.
module uart_tx_serializer #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  shift_en,
    input  logic                  cnt_clr,
    output logic                  ser_data,
    output logic                  ser_done
);

    localparam int unsigned CntW = $clog2(DATA_WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(DATA_WIDTH - 1);

    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [CntW-1:0]       cnt_q, cnt_d;

    assign ser_data = shift_q[0];
    assign ser_done = (cnt_q == CntLast);

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (load) begin
            shift_d = load_data;
            cnt_d   = '0;
        end else if (shift_en) begin
            // Shift on the edge that puts the current ser_data onto the line.
            shift_d = {1'b0, shift_q[DATA_WIDTH-1:1]};
            if (cnt_clr) begin
                cnt_d = '0;
            end else if (!ser_done) begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_frame_ctrl.sv
// UART transmit engine: frame FSM, parity on the latched word and registered
// line/busy outputs loaded on the edge that enters each state.
module uart_tx_frame_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  STOP_2,
    output logic                  TX_OUT,
    output logic                  busy
);

    tx_state_e state_q, state_d;

    logic [DATA_WIDTH-1:0] data_q;
    logic                  par_en_q;
    logic                  par_typ_q;
    logic                  stop2_q;

    logic final_stop;
    logic accept;
    logic parity;
    logic shift_en;
    logic cnt_clr;
    logic ser_data;
    logic ser_done;
    logic tx_d;
    logic busy_d;

    assign final_stop = ((state_q == StStop1) && !stop2_q) || (state_q == StStop2);
    assign accept     = DATA_VALID && ((state_q == StIdle) || final_stop);
    assign parity     = (^data_q) ^ (par_typ_q == PAR_ODD);
    assign shift_en   = (state_q == StStart) || (state_q == StData);
    assign cnt_clr    = (state_q == StStart);

    uart_tx_serializer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_serializer (
        .CLK       (CLK),
        .RST       (RST),
        .load      (accept),
        .load_data (P_DATA),
        .shift_en  (shift_en),
        .cnt_clr   (cnt_clr),
        .ser_data  (ser_data),
        .ser_done  (ser_done)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (accept) state_d = StStart;
            StStart:  state_d = StData;
            StData:   if (ser_done) state_d = par_en_q ? StParity : StStop1;
            StParity: state_d = StStop1;
            StStop1: begin
                if (stop2_q) begin
                    state_d = StStop2;
                end else begin
                    state_d = accept ? StStart : StIdle;
                end
            end
            StStop2:  state_d = accept ? StStart : StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Outputs are decoded from the next state so the flops hold the value of
    // the state being entered.
    always_comb begin
        tx_d   = 1'b1;
        busy_d = 1'b1;
        case (state_d)
            StIdle:   busy_d = 1'b0;
            StStart:  tx_d   = 1'b0;
            StData:   tx_d   = ser_data;
            StParity: tx_d   = parity;
            StStop1:  tx_d   = 1'b1;
            StStop2:  tx_d   = 1'b1;
            default: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= StIdle;
            TX_OUT    <= 1'b1;
            busy      <= 1'b0;
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= PAR_EVEN;
            stop2_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            TX_OUT  <= tx_d;
            busy    <= busy_d;
            if (accept) begin
                data_q    <= P_DATA;
                par_en_q  <= PAR_EN;
                par_typ_q <= PAR_TYP;
                stop2_q   <= STOP_2;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// Directed bench for uart_tx_frame_ctrl at DATA_WIDTH 8 and 5.
module tb_uart_tx_frame_ctrl;

    logic       CLK = 1'b0;
    logic       RST;

    logic [7:0] p_data;
    logic       data_valid, par_en, par_typ, stop_2;
    logic       tx_out, busy;

    logic [4:0] p_data5;
    logic       data_valid5, par_en5, par_typ5, stop_25;
    logic       tx_out5, busy5;

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    uart_tx_frame_ctrl #(
        .DATA_WIDTH (8)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (p_data),
        .DATA_VALID (data_valid),
        .PAR_EN     (par_en),
        .PAR_TYP    (par_typ),
        .STOP_2     (stop_2),
        .TX_OUT     (tx_out),
        .busy       (busy)
    );

    uart_tx_frame_ctrl #(
        .DATA_WIDTH (5)
    ) dut5 (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (p_data5),
        .DATA_VALID (data_valid5),
        .PAR_EN     (par_en5),
        .PAR_TYP    (par_typ5),
        .STOP_2     (stop_25),
        .TX_OUT     (tx_out5),
        .busy       (busy5)
    );

    // Launches one frame on the 8-bit instance and records n line/busy samples,
    // starting with the first cycle after the accept edge. P_DATA is scrambled
    // after accept so a frame that leaks live inputs shows up.
    task automatic send_frame(input logic [7:0] d, input logic pe, input logic pt,
                              input logic s2, input int n,
                              output logic [31:0] line, output logic [31:0] bsy);
        line = '0;
        bsy  = '0;
        @(negedge CLK);
        p_data     = d;
        par_en     = pe;
        par_typ    = pt;
        stop_2     = s2;
        data_valid = 1'b1;
        @(negedge CLK);
        data_valid = 1'b0;
        p_data     = ~d;
        par_en     = ~pe;
        par_typ    = ~pt;
        stop_2     = ~s2;
        for (int i = 0; i < n; i++) begin
            line[i] = tx_out;
            bsy[i]  = busy;
            @(negedge CLK);
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        #2 RST = 1'b0;
        #1;
        checks++;
        if (tx_out !== 1'b1) begin
            failures++;
            $display("FAIL reset_tx8: got %b expected 1", tx_out);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy8: got %b expected 0", busy);
        end
        checks++;
        if (tx_out5 !== 1'b1) begin
            failures++;
            $display("FAIL reset_tx5: got %b expected 1", tx_out5);
        end
        checks++;
        if (busy5 !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy5: got %b expected 0", busy5);
        end
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_no_parity();
        logic [31:0] line, bsy;
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 11, line, bsy);
        checks++;
        if (line[10:0] !== 11'b11101001010) begin
            failures++;
            $display("FAIL a5_noparity_line: got %b expected %b", line[10:0], 11'b11101001010);
        end
        checks++;
        if (bsy[10:0] !== 11'b01111111111) begin
            failures++;
            $display("FAIL a5_noparity_busy: got %b expected %b", bsy[10:0], 11'b01111111111);
        end
    endtask

    task automatic test_parity();
        logic [31:0] line, bsy;
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 12, line, bsy);
        checks++;
        if (line[11:0] !== 12'b110101001010) begin
            failures++;
            $display("FAIL a5_even_line: got %b expected %b", line[11:0], 12'b110101001010);
        end
        checks++;
        if (bsy[11:0] !== 12'b011111111111) begin
            failures++;
            $display("FAIL a5_even_busy: got %b expected %b", bsy[11:0], 12'b011111111111);
        end
        send_frame(8'hA5, 1'b1, 1'b1, 1'b0, 12, line, bsy);
        checks++;
        if (line[11:0] !== 12'b111101001010) begin
            failures++;
            $display("FAIL a5_odd_line: got %b expected %b", line[11:0], 12'b111101001010);
        end
        checks++;
        if (bsy[11:0] !== 12'b011111111111) begin
            failures++;
            $display("FAIL a5_odd_busy: got %b expected %b", bsy[11:0], 12'b011111111111);
        end
    endtask

    task automatic test_two_stop();
        logic [31:0] line, bsy;
        send_frame(8'h0F, 1'b1, 1'b1, 1'b1, 13, line, bsy);
        checks++;
        if (line[12:0] !== 13'b1111000011110) begin
            failures++;
            $display("FAIL 0f_stop2_line: got %b expected %b", line[12:0], 13'b1111000011110);
        end
        checks++;
        if (bsy[12:0] !== 13'b0111111111111) begin
            failures++;
            $display("FAIL 0f_stop2_busy: got %b expected %b", bsy[12:0], 13'b0111111111111);
        end
    endtask

    // First frame 0x3C with two stop bits, second 0xC3 with one; DATA_VALID
    // stays high until the second START is on the line.
    task automatic test_back_to_back();
        logic [31:0] line, bsy;
        line = '0;
        bsy  = '0;
        @(negedge CLK);
        p_data     = 8'h3C;
        par_en     = 1'b0;
        par_typ    = 1'b0;
        stop_2     = 1'b1;
        data_valid = 1'b1;
        @(negedge CLK);
        p_data = 8'hC3;
        stop_2 = 1'b0;
        for (int i = 0; i < 22; i++) begin
            line[i] = tx_out;
            bsy[i]  = busy;
            if (i == 11) data_valid = 1'b0;
            @(negedge CLK);
        end
        checks++;
        if (line[21:0] !== 22'b1111000011011001111000) begin
            failures++;
            $display("FAIL b2b_line: got %b expected %b", line[21:0],
                     22'b1111000011011001111000);
        end
        checks++;
        if (bsy[21:0] !== 22'b0111111111111111111111) begin
            failures++;
            $display("FAIL b2b_busy: got %b expected %b", bsy[21:0],
                     22'b0111111111111111111111);
        end
    endtask

    task automatic test_reset_mid_frame();
        @(negedge CLK);
        p_data     = 8'hA5;
        par_en     = 1'b0;
        par_typ    = 1'b0;
        stop_2     = 1'b0;
        data_valid = 1'b1;
        @(negedge CLK);
        data_valid = 1'b0;
        // Advance to the 4th data bit (0 for 0xA5) so the reset visibly flips the line.
        repeat (4) @(negedge CLK);
        RST = 1'b0;
        #1;
        checks++;
        if (tx_out !== 1'b1) begin
            failures++;
            $display("FAIL midreset_tx: got %b expected 1", tx_out);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL midreset_busy: got %b expected 0", busy);
        end
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            checks++;
            if (tx_out !== 1'b1 || busy !== 1'b0) begin
                failures++;
                $display("FAIL postreset_idle[%0d]: got tx=%b busy=%b expected tx=1 busy=0",
                         i, tx_out, busy);
            end
        end
    endtask

    task automatic test_width5();
        logic [31:0] line, bsy;
        line = '0;
        bsy  = '0;
        @(negedge CLK);
        p_data5     = 5'b10011;
        par_en5     = 1'b1;
        par_typ5    = 1'b0;
        stop_25     = 1'b0;
        data_valid5 = 1'b1;
        @(negedge CLK);
        data_valid5 = 1'b0;
        p_data5     = 5'b01100;
        for (int i = 0; i < 9; i++) begin
            line[i] = tx_out5;
            bsy[i]  = busy5;
            @(negedge CLK);
        end
        checks++;
        if (line[8:0] !== 9'b111100110) begin
            failures++;
            $display("FAIL w5_line: got %b expected %b", line[8:0], 9'b111100110);
        end
        checks++;
        if (bsy[8:0] !== 9'b011111111) begin
            failures++;
            $display("FAIL w5_busy: got %b expected %b", bsy[8:0], 9'b011111111);
        end
    endtask

    initial begin
        p_data      = '0;
        data_valid  = 1'b0;
        par_en      = 1'b0;
        par_typ     = 1'b0;
        stop_2      = 1'b0;
        p_data5     = '0;
        data_valid5 = 1'b0;
        par_en5     = 1'b0;
        par_typ5    = 1'b0;
        stop_25     = 1'b0;

        test_reset();
        test_no_parity();
        test_parity();
        test_two_stop();
        test_back_to_back();
        test_reset_mid_frame();
        test_width5();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
